// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: IDLE/ACCESS/DONE handshake with lane steering and load extension.
// Optional MISALIGN_TRAP_EN turns misaligned halves/words into a strobe-less trap through DONE.
module mem_access_unit (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  IN_READ_WRITE,
    input  logic [31:0] IN_ALU_RESULT,
    input  logic [31:0] IN_DATA2,
    output logic [31:0] MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    output logic [3:0]  MEM_BYTE_EN,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_ACK,
    output logic [31:0] OUT_READ_DATA,
    output logic        BUSYWAIT,
    output logic        MISALIGNED
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  be_q;
    logic        rd_q, wr_q, uns_q;
    logic [1:0]  sz_q, off_q;

    logic        is_load, is_store, acc_vld, mis;
    logic [1:0]  sz_d, off_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, ld_ext;
    logic [7:0]  rd_b;
    logic [15:0] rd_h;

    assign off_d = IN_ALU_RESULT[1:0];
    assign sz_d  = IN_READ_WRITE[1:0];

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        case (IN_READ_WRITE)
            4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101: is_load  = 1'b1;
            4'b0100, 4'b0101, 4'b0110:                   is_store = 1'b1;
            default: ;
        endcase
    end

    assign acc_vld = is_load | is_store;

`ifdef MISALIGN_TRAP_EN
    logic mis_q;
    always_comb begin
        mis = 1'b0;
        if (acc_vld) begin
            case (sz_d)
                2'b01:   mis = off_d[0];
                2'b10:   mis = (off_d != 2'b00);
                default: mis = 1'b0;
            endcase
        end
    end
    assign MISALIGNED = mis_q;
`else
    assign mis        = 1'b0;
    assign MISALIGNED = 1'b0;
`endif

    // Lane steering is shared by loads and stores; loads only use the address.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = IN_DATA2;
        case (sz_d)
            2'b00: begin
                be_d    = 4'b0001 << off_d;
                wdata_d = {4{IN_DATA2[7:0]}};
            end
            2'b01: begin
                be_d    = off_d[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{IN_DATA2[15:0]}};
            end
            default: ;
        endcase
    end

    assign rd_b = MEM_READDATA[{off_q, 3'b000} +: 8];
    assign rd_h = off_q[1] ? MEM_READDATA[31:16] : MEM_READDATA[15:0];

    always_comb begin
        case (sz_q)
            2'b00:   ld_ext = uns_q ? {24'b0, rd_b} : {{24{rd_b[7]}}, rd_b};
            2'b01:   ld_ext = uns_q ? {16'b0, rd_h} : {{16{rd_h[15]}}, rd_h};
            default: ld_ext = MEM_READDATA;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
            be_q    <= 4'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            uns_q   <= 1'b0;
            sz_q    <= 2'b0;
            off_q   <= 2'b0;
            rdata_q <= 32'b0;
`ifdef MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (acc_vld) begin
                        if (mis) begin
                            state_q <= DONE;
`ifdef MISALIGN_TRAP_EN
                            mis_q   <= 1'b1;
`endif
                        end else begin
                            state_q <= ACCESS;
                            rd_q    <= is_load;
                            wr_q    <= is_store;
                            addr_q  <= {IN_ALU_RESULT[31:2], 2'b00};
                            wdata_q <= wdata_d;
                            be_q    <= be_d;
                            sz_q    <= sz_d;
                            off_q   <= off_d;
                            uns_q   <= IN_READ_WRITE[2];
                        end
                    end
                end
                ACCESS: begin
                    if (MEM_ACK) begin
                        state_q <= DONE;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        if (rd_q) rdata_q <= ld_ext;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
`ifdef MISALIGN_TRAP_EN
                    mis_q   <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The IDLE term is gated by RESET so the stall never asserts while reset is held.
    assign BUSYWAIT      = ~RESET & (((state_q == IDLE) & acc_vld) | (state_q == ACCESS));
    assign MEM_ADDRESS   = addr_q;
    assign MEM_WRITEDATA = wdata_q;
    assign MEM_BYTE_EN   = be_q;
    assign MEM_READ      = rd_q;
    assign MEM_WRITE     = wr_q;
    assign OUT_READ_DATA = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: load extension, store lanes, ACK latency, reset, misalign.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  IN_READ_WRITE;
    logic [31:0] IN_ALU_RESULT, IN_DATA2;
    logic [31:0] MEM_ADDRESS, MEM_WRITEDATA;
    logic [3:0]  MEM_BYTE_EN;
    logic        MEM_READ, MEM_WRITE;
    logic [31:0] MEM_READDATA;
    logic        MEM_ACK;
    logic [31:0] OUT_READ_DATA;
    logic        BUSYWAIT, MISALIGNED;

    int errs = 0;
    int nchk = 0;

    mem_access_unit dut (
        .CLK(CLK), .RESET(RESET),
        .IN_READ_WRITE(IN_READ_WRITE), .IN_ALU_RESULT(IN_ALU_RESULT), .IN_DATA2(IN_DATA2),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_BYTE_EN(MEM_BYTE_EN),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_READDATA(MEM_READDATA),
        .MEM_ACK(MEM_ACK), .OUT_READ_DATA(OUT_READ_DATA), .BUSYWAIT(BUSYWAIT),
        .MISALIGNED(MISALIGNED)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One full transaction: issue in IDLE, ACK after nwait ACCESS cycles, check DONE and release.
    task automatic run(input string tag, input logic [3:0] code, input logic [31:0] addr,
                       input logic [31:0] d2, input logic [31:0] rdata, input int nwait,
                       input logic is_ld, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd, input logic [31:0] exp_out);
        int busy = 0;
        @(posedge CLK); #1;
        IN_READ_WRITE = code; IN_ALU_RESULT = addr; IN_DATA2 = d2;
        MEM_READDATA = rdata; MEM_ACK = 1'b0;
        #1;
        chk({tag, ".bw_idle"}, {31'b0, BUSYWAIT}, 32'd1);
        chk({tag, ".strb_idle"}, {30'b0, MEM_READ, MEM_WRITE}, 32'd0);
        if (BUSYWAIT) busy++;
        for (int k = 0; k <= nwait; k++) begin
            @(posedge CLK); #1;
            MEM_ACK = (k == nwait);
            #1;
            if (BUSYWAIT) busy++;
            chk({tag, ".rd"}, {31'b0, MEM_READ}, {31'b0, is_ld});
            chk({tag, ".wr"}, {31'b0, MEM_WRITE}, {31'b0, ~is_ld});
            chk({tag, ".addr"}, MEM_ADDRESS, exp_addr);
            if (!is_ld) begin
                chk({tag, ".be"}, {28'b0, MEM_BYTE_EN}, {28'b0, exp_be});
                chk({tag, ".wd"}, MEM_WRITEDATA, exp_wd);
            end
        end
        @(posedge CLK); #1;
        MEM_ACK = 1'b0;
        #1;
        chk({tag, ".bw_done"}, {31'b0, BUSYWAIT}, 32'd0);
        chk({tag, ".strb_done"}, {30'b0, MEM_READ, MEM_WRITE}, 32'd0);
        chk({tag, ".out"}, OUT_READ_DATA, exp_out);
        chk({tag, ".mis"}, {31'b0, MISALIGNED}, 32'd0);
        chk({tag, ".stall"}, busy, nwait + 2);
        @(posedge CLK); #1;
        IN_READ_WRITE = 4'b0000;
        #1;
        chk({tag, ".noreissue"}, {30'b0, MEM_READ, MEM_WRITE}, 32'd0);
        chk({tag, ".bw_after"}, {31'b0, BUSYWAIT}, 32'd0);
    endtask

    initial begin
        RESET = 1'b1;
        IN_READ_WRITE = 4'b1010; IN_ALU_RESULT = 32'h100; IN_DATA2 = 32'b0;
        MEM_READDATA = 32'b0; MEM_ACK = 1'b0;
        #2;
        chk("rst.out", OUT_READ_DATA, 32'd0);
        chk("rst.strb", {30'b0, MEM_READ, MEM_WRITE}, 32'd0);
        chk("rst.mis", {31'b0, MISALIGNED}, 32'd0);
        chk("rst.bw", {31'b0, BUSYWAIT}, 32'd0);
        IN_READ_WRITE = 4'b0000;
        @(posedge CLK); #1;
        RESET = 1'b0;
        #1;
        chk("idle.bw", {31'b0, BUSYWAIT}, 32'd0);

        run("lw",  4'b1010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b1, 32'h100, 4'h0, 32'h0, 32'hDEADBEEF);
        run("lb",  4'b1000, 32'h103, 32'h0, 32'h80112233, 0, 1'b1, 32'h100, 4'h0, 32'h0, 32'hFFFFFF80);
        run("lbu", 4'b1100, 32'h103, 32'h0, 32'h80112233, 1, 1'b1, 32'h100, 4'h0, 32'h0, 32'h00000080);
        run("lhu", 4'b1101, 32'h102, 32'h0, 32'h80112233, 0, 1'b1, 32'h100, 4'h0, 32'h0, 32'h00008011);
        run("lh0", 4'b1001, 32'h100, 32'h0, 32'h80117FFF, 0, 1'b1, 32'h100, 4'h0, 32'h0, 32'h00007FFF);
        run("lh2", 4'b1001, 32'h102, 32'h0, 32'h80112233, 2, 1'b1, 32'h100, 4'h0, 32'h0, 32'hFFFF8011);
        run("lb1", 4'b1000, 32'h101, 32'h0, 32'h80114233, 0, 1'b1, 32'h100, 4'h0, 32'h0, 32'h00000042);
        run("sb",  4'b0100, 32'h201, 32'h000000AB, 32'h0, 0, 1'b0, 32'h200, 4'b0010, 32'hABABABAB, 32'h00000042);
        run("sh",  4'b0101, 32'h202, 32'h1234CDEF, 32'h0, 1, 1'b0, 32'h200, 4'b1100, 32'hCDEFCDEF, 32'h00000042);
        run("sw",  4'b0110, 32'h204, 32'hA5A55A5A, 32'h0, 5, 1'b0, 32'h204, 4'b1111, 32'hA5A55A5A, 32'h00000042);

        // Unused codes and a stray ACK in IDLE must do nothing.
        @(posedge CLK); #1;
        IN_READ_WRITE = 4'b1111; MEM_ACK = 1'b1; MEM_READDATA = 32'h12345678;
        #1;
        chk("bad.bw", {31'b0, BUSYWAIT}, 32'd0);
        @(posedge CLK); #1;
        IN_READ_WRITE = 4'b0000; MEM_ACK = 1'b0;
        #1;
        chk("bad.strb", {30'b0, MEM_READ, MEM_WRITE}, 32'd0);
        chk("bad.out", OUT_READ_DATA, 32'h00000042);

        // Reset in the middle of an ACCESS abandons the load.
        @(posedge CLK); #1;
        IN_READ_WRITE = 4'b1010; IN_ALU_RESULT = 32'h300; MEM_READDATA = 32'h11111111;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("mid.rd", {31'b0, MEM_READ}, 32'd1);
        RESET = 1'b1;
        #1;
        chk("mid.rd_rst", {31'b0, MEM_READ}, 32'd0);
        chk("mid.bw_rst", {31'b0, BUSYWAIT}, 32'd0);
        chk("mid.out_rst", OUT_READ_DATA, 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0; IN_READ_WRITE = 4'b0000; MEM_ACK = 1'b1;
        @(posedge CLK); #1;
        MEM_ACK = 1'b0;
        #1;
        chk("mid.out_ack", OUT_READ_DATA, 32'd0);
        chk("mid.strb_ack", {30'b0, MEM_READ, MEM_WRITE}, 32'd0);
        chk("mid.bw_ack", {31'b0, BUSYWAIT}, 32'd0);
        run("lw_post", 4'b1010, 32'h300, 32'h0, 32'h0BADF00D, 0, 1'b1, 32'h300, 4'h0, 32'h0, 32'h0BADF00D);

`ifdef MISALIGN_TRAP_EN
        @(posedge CLK); #1;
        IN_READ_WRITE = 4'b1010; IN_ALU_RESULT = 32'h102; MEM_READDATA = 32'hCAFEF00D;
        #1;
        chk("mis.bw_idle", {31'b0, BUSYWAIT}, 32'd1);
        chk("mis.mis_idle", {31'b0, MISALIGNED}, 32'd0);
        @(posedge CLK); #1;
        chk("mis.rd_done", {31'b0, MEM_READ}, 32'd0);
        chk("mis.bw_done", {31'b0, BUSYWAIT}, 32'd0);
        chk("mis.flag_done", {31'b0, MISALIGNED}, 32'd1);
        chk("mis.out", OUT_READ_DATA, 32'h0BADF00D);
        @(posedge CLK); #1;
        IN_READ_WRITE = 4'b0000;
        #1;
        chk("mis.flag_idle", {31'b0, MISALIGNED}, 32'd0);
        chk("mis.rd_idle", {31'b0, MEM_READ}, 32'd0);
`else
        run("lw_unal", 4'b1010, 32'h102, 32'h0, 32'hCAFEF00D, 0, 1'b1, 32'h100, 4'h0, 32'h0, 32'hCAFEF00D);
        run("sh_unal", 4'b0101, 32'h203, 32'h00005566, 32'h0, 0, 1'b0, 32'h200, 4'b1100, 32'h55665566, 32'hCAFEF00D);
`endif

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
